kbd_fifo_slave: RTL and testbench

- Wishbone slave that buffers PS/2 scan codes between the keyboard device (Keyboard_Data / ready_pulse) and the bus intercon.
- Replaces the direct keyboard driver path so that key bytes are not lost while the CPU is busy.
- Provides a popping data register, a status register and a control register on the keyboard slave slot (slave 3).

---
 rtl/kbd_fifo_slave_pkg.sv | 46 ++++
 rtl/kbd_fifo_core.sv | 86 ++++++++
 rtl/kbd_fifo_slave.sv | 144 ++++++++++++++
 tb/tb_kbd_fifo_slave.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_fifo_slave_pkg.sv
// kbd_fifo_slave_pkg
//   Shared definitions for the keyboard FIFO Wishbone slave: register offsets
//   (decoded from ADDR[1:0]), CONTROL bit indices, DATA/STATUS bit positions
//   and the bus FSM state encoding.
package kbd_fifo_slave_pkg;

  // Register offsets, word addressed
  localparam logic [1:0] KBD_REG_DATA   = 2'd0;
  localparam logic [1:0] KBD_REG_STATUS = 2'd1;
  localparam logic [1:0] KBD_REG_CTRL   = 2'd2;

  // CONTROL write bits
  localparam int unsigned KBD_CTRL_FLUSH   = 0;
  localparam int unsigned KBD_CTRL_CLR_OVF = 1;

  // DATA read word: {23'b0, valid, code}
  localparam int unsigned KBD_DATA_VALID = 8;

  // STATUS read word: {21'b0, overflow, full, empty, 3'b0, count[4:0]}
  localparam int unsigned KBD_STAT_COUNT_W = 5;
  localparam int unsigned KBD_STAT_EMPTY   = 8;
  localparam int unsigned KBD_STAT_FULL    = 9;
  localparam int unsigned KBD_STAT_OVF     = 10;

  // Bus handshake FSM
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAck     = 2'd1,
    StRelease = 2'd2
  } kbd_bus_state_e;

  // Assemble the STATUS read word
  function automatic logic [31:0] kbd_pack_status(input logic                        overflow,
                                                  input logic                        full,
                                                  input logic                        empty,
                                                  input logic [KBD_STAT_COUNT_W-1:0] count);
    logic [31:0] word;
    word                           = '0;
    word[KBD_STAT_COUNT_W-1:0]     = count;
    word[KBD_STAT_EMPTY]           = empty;
    word[KBD_STAT_FULL]            = full;
    word[KBD_STAT_OVF]             = overflow;
    return word;
  endfunction

endpackage

// File: rtl/kbd_fifo_core.sv
// kbd_fifo_core
//   Synchronous first-word-fall-through FIFO for keyboard scan codes.
//   rd_data always shows the oldest entry, so it is valid in the same cycle as pop.
//   Ports:
//     clk, reset (async, active low)
//     push, wr_data    - write request and data (ignored when full unless popping)
//     pop              - read request (ignored when empty)
//     flush            - clear pointers and count; overrides push and pop
//     rd_data          - head entry
//     full, empty      - occupancy flags
//     count            - number of stored entries, 0..2**DEPTH_LOG2
module kbd_fifo_core #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned DATA_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [DATA_W-1:0]     mem_q [Depth];

  logic do_push;
  logic do_pop;

  // count never exceeds Depth, so its MSB alone marks full
  assign full    = count_q[DEPTH_LOG2];
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rptr_q];

  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs
  assign do_push = push & (~full | do_pop);

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (flush) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the count gates what is ever read out
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_q[wptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/kbd_fifo_slave.sv
// kbd_fifo_slave
//   Wishbone slave buffering PS/2 scan codes from the keyboard device so key
//   bytes survive while the CPU is busy.
//   Registers (ADDR[1:0]):
//     0 DATA    R  {23'b0, valid, code}; a read pops one entry
//     1 STATUS  R  {21'b0, overflow, full, empty, 3'b0, count[4:0]}
//     2 CONTROL W  bit0 flush, bit1 clear overflow; reads 0
//     3 -          reads 0, writes ignored
//   Ports:
//     clk, reset (async, active low)
//     Keyboard_Data, ready_pulse - scan code and its one-cycle strobe
//     STB, WE, ADDR, DAT_I       - bus request from the intercon
//     DAT_O, ACK                 - read data and one-cycle acknowledge
//     irq                        - high while the FIFO holds data (registered)
module kbd_fifo_slave
  import kbd_fifo_slave_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned DATA_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] Keyboard_Data,
  input  logic              ready_pulse,
  input  logic              STB,
  input  logic              WE,
  input  logic [31:0]       ADDR,
  input  logic [31:0]       DAT_I,
  output logic [31:0]       DAT_O,
  output logic              ACK,
  output logic              irq
);

  kbd_bus_state_e state_q, state_d;
  logic [31:0]    dat_q, dat_d;
  logic           ack_q;
  logic           ovf_q, ovf_d;
  logic           irq_q;

  logic              fifo_pop;
  logic              fifo_flush;
  logic              clr_ovf;
  logic              ovf_set;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DEPTH_LOG2:0] fifo_count;

  // Upper address/data bits are not decoded
  logic unused_bus_bits;
  assign unused_bus_bits = ^{ADDR[31:2], DAT_I[31:2]};

  kbd_fifo_core #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (ready_pulse),
    .wr_data (Keyboard_Data),
    .pop     (fifo_pop),
    .flush   (fifo_flush),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Bus FSM: all side effects happen once, in the IDLE cycle that sees STB.
  // RELEASE waits for STB to drop so a held strobe cannot pop twice.
  always_comb begin
    state_d    = state_q;
    dat_d      = dat_q;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    clr_ovf    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (STB) begin
          state_d = StAck;
          dat_d   = '0;
          if (WE) begin
            if (ADDR[1:0] == KBD_REG_CTRL) begin
              fifo_flush = DAT_I[KBD_CTRL_FLUSH];
              clr_ovf    = DAT_I[KBD_CTRL_CLR_OVF];
            end
          end else begin
            unique case (ADDR[1:0])
              KBD_REG_DATA: begin
                if (!fifo_empty) begin
                  fifo_pop                  = 1'b1;
                  dat_d[DATA_W-1:0]         = fifo_rd_data;
                  dat_d[KBD_DATA_VALID]     = 1'b1;
                end
              end
              KBD_REG_STATUS: begin
                dat_d = kbd_pack_status(ovf_q, fifo_full, fifo_empty,
                                        KBD_STAT_COUNT_W'(fifo_count));
              end
              default: dat_d = '0;
            endcase
          end
        end
      end
      StAck:     state_d = StRelease;
      StRelease: if (!STB) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // A dropped byte sets overflow unless a pop frees room or a flush discards it;
  // a set beats a simultaneous clear.
  assign ovf_set = ready_pulse & fifo_full & ~fifo_pop & ~fifo_flush;

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      dat_q   <= '0;
      ack_q   <= 1'b0;
      ovf_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dat_q   <= dat_d;
      ack_q   <= (state_q == StAck);
      ovf_q   <= ovf_d;
      irq_q   <= ~fifo_empty;
    end
  end

  assign DAT_O = dat_q;
  assign ACK   = ack_q;
  assign irq   = irq_q;

endmodule

// File: tb/tb_kbd_fifo_slave.sv
module tb_kbd_fifo_slave;

  logic        clk;
  logic        reset;
  logic [7:0]  Keyboard_Data;
  logic        ready_pulse;
  logic        STB;
  logic        WE;
  logic [31:0] ADDR;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic        ACK;
  logic        irq;

  int checks;
  int errors;

  kbd_fifo_slave #(
    .DEPTH_LOG2 (4),
    .DATA_W     (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .Keyboard_Data (Keyboard_Data),
    .ready_pulse   (ready_pulse),
    .STB           (STB),
    .WE            (WE),
    .ADDR          (ADDR),
    .DAT_I         (DAT_I),
    .DAT_O         (DAT_O),
    .ACK           (ACK),
    .irq           (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not end, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // One-cycle keyboard strobe
  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    ready_pulse   = 1'b1;
    Keyboard_Data = b;
    @(negedge clk);
    ready_pulse   = 1'b0;
  endtask

  // Bus access; lat = clock edges from STB to ACK (0 = timed out),
  // ack_after = ACK one cycle after it was seen.
  task automatic bus_xfer(input logic we, input logic [1:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat, output logic ack_after);
    @(negedge clk);
    STB   = 1'b1;
    WE    = we;
    ADDR  = {30'b0, a};
    DAT_I = wd;
    lat   = 0;
    rd    = '0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (ACK) begin
        lat = i;
        break;
      end
    end
    if (lat != 0) rd = DAT_O;
    STB = 1'b0;
    WE  = 1'b0;
    @(posedge clk);
    #1;
    ack_after = ACK;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    int          lat;
    logic        aa;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ACK !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b required 0", ACK); end
    checks++; if (DAT_O !== 32'h0) begin errors++; $display("FAIL reset_dat: got %h required 0", DAT_O); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b required 0", irq); end
    reset = 1'b1;
    bus_xfer(1'b0, 2'd1, 32'h0, rd, lat, aa);
    checks++; if (lat !== 2) begin errors++; $display("FAIL reset_latency: got %0d required 2", lat); end
    checks++; if (rd !== 32'h0000_0100) begin errors++; $display("FAIL reset_status: got %h required 00000100", rd); end
    bus_xfer(1'b0, 2'd0, 32'h0, rd, lat, aa);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_data_empty: got %h required 0", rd); end
    checks++; if (aa !== 1'b0) begin errors++; $display("FAIL reset_ack_width: got %b required 0", aa); end
  endtask

  task automatic test_fifo_order();
    logic [31:0] rd;
    int          lat;
    logic        aa;
    logic [31:0] exp [3];
    exp[0] = 32'h11C; exp[1] = 32'h1F0; exp[2] = 32'h11C;
    push_byte(8'h1C);
    push_byte(8'hF0);
    push_byte(8'h1C);
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL order_irq_set: got %b required 1", irq); end
    bus_xfer(1'b0, 2'd1, 32'h0, rd, lat, aa);
    checks++; if (rd !== 32'h0000_0003) begin errors++; $display("FAIL order_status: got %h required 00000003", rd); end
    for (int i = 0; i < 3; i++) begin
      bus_xfer(1'b0, 2'd0, 32'h0, rd, lat, aa);
      checks++;
      if (rd !== exp[i]) begin
        errors++; $display("FAIL order_data%0d: got %h required %h", i, rd, exp[i]);
      end
    end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL order_irq_clear: got %b required 0", irq); end
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    int          lat;
    logic        aa;
    for (int i = 0; i < 17; i++) push_byte(8'(i));
    bus_xfer(1'b0, 2'd1, 32'h0, rd, lat, aa);
    checks++; if (rd !== 32'h0000_0610) begin errors++; $display("FAIL ovf_status: got %h required 00000610", rd); end
    for (int i = 0; i < 16; i++) begin
      bus_xfer(1'b0, 2'd0, 32'h0, rd, lat, aa);
      checks++;
      if (rd !== (32'h100 | 32'(i))) begin
        errors++; $display("FAIL ovf_data%0d: got %h required %h", i, rd, 32'h100 | 32'(i));
      end
    end
    bus_xfer(1'b0, 2'd1, 32'h0, rd, lat, aa);
    checks++; if (rd !== 32'h0000_0500) begin errors++; $display("FAIL ovf_sticky: got %h required 00000500", rd); end
    bus_xfer(1'b1, 2'd2, 32'h2, rd, lat, aa);
    checks++; if (lat !== 2) begin errors++; $display("FAIL ovf_ctrl_ack: got %0d required 2", lat); end
    bus_xfer(1'b0, 2'd1, 32'h0, rd, lat, aa);
    checks++; if (rd !== 32'h0000_0100) begin errors++; $display("FAIL ovf_cleared: got %h required 00000100", rd); end
  endtask

  task automatic test_stb_hold();
    logic [31:0] rd;
    logic [31:0] cap;
    int          lat;
    int          acks;
    logic        aa;
    push_byte(8'hA1);
    push_byte(8'hA2);
    @(negedge clk);
    STB = 1'b1; WE = 1'b0; ADDR = 32'h0;
    acks = 0;
    cap  = '0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (ACK) begin
        acks++;
        cap = DAT_O;
      end
    end
    STB = 1'b0;
    repeat (2) @(posedge clk);
    checks++; if (acks !== 1) begin errors++; $display("FAIL hold_ack_count: got %0d required 1", acks); end
    checks++; if (cap !== 32'h1A1) begin errors++; $display("FAIL hold_data: got %h required 000001a1", cap); end
    bus_xfer(1'b0, 2'd1, 32'h0, rd, lat, aa);
    checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL hold_status: got %h required 00000001", rd); end
    bus_xfer(1'b0, 2'd0, 32'h0, rd, lat, aa);
    checks++; if (rd !== 32'h1A2) begin errors++; $display("FAIL hold_drain: got %h required 000001a2", rd); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] rd;
    logic [31:0] exp;
    int          lat;
    logic        aa;
    for (int i = 0; i < 16; i++) push_byte(8'h30 + 8'(i));
    // DATA read pops in the same cycle the keyboard strobes 0xAA
    @(negedge clk);
    STB = 1'b1; WE = 1'b0; ADDR = 32'h0;
    ready_pulse = 1'b1; Keyboard_Data = 8'hAA;
    @(negedge clk);
    ready_pulse = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (ACK !== 1'b1) begin errors++; $display("FAIL fpp_ack: got %b required 1", ACK); end
    checks++; if (DAT_O !== 32'h130) begin errors++; $display("FAIL fpp_first: got %h required 00000130", DAT_O); end
    STB = 1'b0;
    @(posedge clk);
    #1;
    bus_xfer(1'b0, 2'd1, 32'h0, rd, lat, aa);
    checks++; if (rd !== 32'h0000_0210) begin errors++; $display("FAIL fpp_status: got %h required 00000210", rd); end
    for (int i = 1; i <= 16; i++) begin
      exp = (i == 16) ? 32'h1AA : (32'h130 + 32'(i));
      bus_xfer(1'b0, 2'd0, 32'h0, rd, lat, aa);
      checks++;
      if (rd !== exp) begin
        errors++; $display("FAIL fpp_data%0d: got %h required %h", i, rd, exp);
      end
    end
  endtask

  task automatic test_misc_regs();
    logic [31:0] rd;
    int          lat;
    logic        aa;
    push_byte(8'h77);
    bus_xfer(1'b1, 2'd0, 32'hFFFF_FFFF, rd, lat, aa);
    checks++; if (lat !== 2) begin errors++; $display("FAIL misc_wr_data_ack: got %0d required 2", lat); end
    bus_xfer(1'b0, 2'd1, 32'h0, rd, lat, aa);
    checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL misc_status: got %h required 00000001", rd); end
    bus_xfer(1'b0, 2'd3, 32'h0, rd, lat, aa);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL misc_reg3: got %h required 0", rd); end
    bus_xfer(1'b0, 2'd2, 32'h0, rd, lat, aa);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL misc_ctrl_read: got %h required 0", rd); end
    bus_xfer(1'b0, 2'd0, 32'h0, rd, lat, aa);
    checks++; if (rd !== 32'h177) begin errors++; $display("FAIL misc_drain: got %h required 00000177", rd); end
  endtask

  task automatic test_flush_reset();
    logic [31:0] rd;
    int          lat;
    logic        aa;
    push_byte(8'h11);
    push_byte(8'h22);
    // Flush write coincides with a keyboard strobe carrying 0x55
    @(negedge clk);
    STB = 1'b1; WE = 1'b1; ADDR = 32'h2; DAT_I = 32'h1;
    ready_pulse = 1'b1; Keyboard_Data = 8'h55;
    @(negedge clk);
    ready_pulse = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (ACK !== 1'b1) begin errors++; $display("FAIL flush_ack: got %b required 1", ACK); end
    STB = 1'b0; WE = 1'b0;
    @(posedge clk);
    #1;
    bus_xfer(1'b0, 2'd1, 32'h0, rd, lat, aa);
    checks++; if (rd !== 32'h0000_0100) begin errors++; $display("FAIL flush_status: got %h required 00000100", rd); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL flush_irq: got %b required 0", irq); end
    // Reset while ACK is high
    push_byte(8'h66);
    @(negedge clk);
    STB = 1'b1; WE = 1'b0; ADDR = 32'h1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checks++; if (ACK !== 1'b1) begin errors++; $display("FAIL rst_mid_pre_ack: got %b required 1", ACK); end
    reset = 1'b0;
    #1;
    checks++; if (ACK !== 1'b0) begin errors++; $display("FAIL rst_mid_ack: got %b required 0", ACK); end
    checks++; if (DAT_O !== 32'h0) begin errors++; $display("FAIL rst_mid_dat: got %h required 0", DAT_O); end
    STB = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    bus_xfer(1'b0, 2'd1, 32'h0, rd, lat, aa);
    checks++; if (lat !== 2) begin errors++; $display("FAIL rst_mid_relatency: got %0d required 2", lat); end
    checks++; if (rd !== 32'h0000_0100) begin errors++; $display("FAIL rst_mid_status: got %h required 00000100", rd); end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b0;
    Keyboard_Data = 8'h0;
    ready_pulse   = 1'b0;
    STB           = 1'b0;
    WE            = 1'b0;
    ADDR          = 32'h0;
    DAT_I         = 32'h0;
    test_reset();
    test_fifo_order();
    test_overflow();
    test_stb_hold();
    test_full_push_pop();
    test_misc_regs();
    test_flush_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
